// File: rtl/bit_iter_if.sv
// bit_iter_if: word-in / beat-out handshake bundle for bit_iter.
interface bit_iter_if #(parameter int W = 32);
    localparam int LW = $clog2(W);
    logic          in_vld_i;
    logic          in_rdy_o;
    logic [W-1:0]  in_x_i;
    logic [LW-1:0] in_pos_i;
    logic          out_vld_o;
    logic          out_rdy_i;
    logic          out_any_o;
    logic [LW-1:0] out_idx_o;
    logic [W-1:0]  out_onehot_o;
    logic          out_last_o;
    modport master (
        output in_vld_i, in_x_i, in_pos_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, out_any_o, out_idx_o, out_onehot_o, out_last_o
    );
    modport slave (
        input  in_vld_i, in_x_i, in_pos_i, out_rdy_i,
        output in_rdy_o, out_vld_o, out_any_o, out_idx_o, out_onehot_o, out_last_o
    );
endinterface

// File: rtl/bit_iter.sv
// bit_iter: emits every set bit of a captured word, one per cycle, in circular order from a start position.
module bit_iter #(parameter int W = 32) (
    input  logic      clk,
    input  logic      arst_n,
    bit_iter_if.slave bus
);
    localparam int LW = $clog2(W);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        r_state, w_next;
    logic [W-1:0]  r_mask;
    logic [LW-1:0] r_pos;
    logic          r_zero;
    logic [W-1:0]  w_rot, w_onehot;
    logic [LW-1:0] w_off, w_idx;
    logic          w_busy, w_any, w_single, w_take, w_fire;
    // Rotating by the start position turns the circular scan into a plain lowest-set-bit search.
    assign w_rot = W'({r_mask, r_mask} >> r_pos);
    always_comb begin
        w_off = '0;
        for (int k = W - 1; k >= 0; k--) if (w_rot[k]) w_off = LW'(k);
    end
    assign w_idx    = r_pos + w_off;
    assign w_busy   = r_state == BUSY;
    assign w_any    = w_busy & ~r_zero;
    assign w_onehot = w_any ? W'(1) << w_idx : '0;
    assign w_single = (r_mask & (r_mask - W'(1))) == '0;
    assign w_take   = bus.in_vld_i & ~w_busy;
    assign w_fire   = w_busy & bus.out_rdy_i;
    assign bus.in_rdy_o     = ~w_busy;
    assign bus.out_vld_o    = w_busy;
    assign bus.out_any_o    = w_any;
    assign bus.out_idx_o    = w_any ? w_idx : '0;
    assign bus.out_onehot_o = w_onehot;
    assign bus.out_last_o   = w_busy & w_single;
    always_comb begin
        w_next = w_take ? BUSY : (w_fire & w_single) ? IDLE : r_state;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_pos   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_mask <= bus.in_x_i;
                r_pos  <= bus.in_pos_i;
                r_zero <= bus.in_x_i == '0;
            end else if (w_fire) begin
                r_mask <= r_mask & ~w_onehot;
            end
        end
    end
endmodule

// File: tb/tb_bit_iter.sv
// tb_bit_iter: directed table plus randomized words checked against a circular-scan reference model.
module tb_bit_iter;
    logic clk = 1'b0;
    logic arst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    bit_iter_if #(.W(8)) bus();
    bit_iter #(.W(8)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [2:0]  pos;
        int          n;
        logic [31:0] seq;
        int          sb;
        int          sl;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic beat(input int i, input int n, input logic [2:0] e, input logic z);
        chk($sformatf("vld[%0d]", i), 32'(bus.out_vld_o), 1);
        chk("rdy_busy", 32'(bus.in_rdy_o), 0);
        chk("any", 32'(bus.out_any_o), 32'(!z));
        chk($sformatf("idx[%0d]", i), 32'(bus.out_idx_o), z ? 0 : 32'(e));
        chk("onehot", 32'(bus.out_onehot_o), z ? 0 : 32'(8'(1) << e));
        chk("last", 32'(bus.out_last_o), 32'(i == n - 1));
    endtask

    task automatic accept(input logic [7:0] x, input logic [2:0] pos);
        int g = 0;
        while (bus.in_rdy_o !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("accept_rdy", 32'(bus.in_rdy_o), 1);
        bus.in_vld_i = 1'b1;
        bus.in_x_i   = x;
        bus.in_pos_i = pos;
        @(negedge clk);
        bus.in_vld_i = 1'b0;
        bus.in_x_i   = 8'($urandom);
        bus.in_pos_i = 3'($urandom);
    endtask

    task automatic run_word(input logic [7:0] x, input logic [2:0] pos, input int n,
                            input logic [31:0] seq, input int sb, input int sl, input bit rnd);
        accept(x, pos);
        for (int i = 0; i < n; i++) begin
            logic [2:0] e;
            int st;
            e  = seq[4*i +: 3];
            st = (i == sb) ? sl : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            beat(i, n, e, x == 8'h00);
            for (int s = 0; s < st; s++) begin
                bus.out_rdy_i = 1'b0;
                @(negedge clk);
                beat(i, n, e, x == 8'h00);
            end
            bus.out_rdy_i = 1'b1;
            @(negedge clk);
        end
        chk("bubble_vld", 32'(bus.out_vld_o), 0);
        chk("bubble_rdy", 32'(bus.in_rdy_o), 1);
    endtask

    // Reference: walk offsets 0..7 from pos and list each set bit met.
    function automatic void model(input logic [7:0] x, input logic [2:0] pos,
                                  output int n, output logic [31:0] seq);
        n   = 0;
        seq = '0;
        for (int k = 0; k < 8; k++) begin
            int b;
            b = (int'(pos) + k) % 8;
            if (x[b]) begin
                seq[4*n +: 4] = 4'(b);
                n++;
            end
        end
        if (n == 0) n = 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_vld_i  = 1'b0;
        bus.in_x_i    = '0;
        bus.in_pos_i  = '0;
        bus.out_rdy_i = 1'b1;
        vt[0] = '{x: 8'h96, pos: 3'd0, n: 4, seq: 32'h0000_7421, sb: -1, sl: 0};
        vt[1] = '{x: 8'h96, pos: 3'd5, n: 4, seq: 32'h0000_4217, sb: -1, sl: 0};
        vt[2] = '{x: 8'h00, pos: 3'd3, n: 1, seq: 32'h0,         sb: -1, sl: 0};
        vt[3] = '{x: 8'hFF, pos: 3'd7, n: 8, seq: 32'h6543_2107, sb: 1,  sl: 3};
        vt[4] = '{x: 8'h01, pos: 3'd6, n: 1, seq: 32'h0,         sb: -1, sl: 0};
        vt[5] = '{x: 8'h80, pos: 3'd0, n: 1, seq: 32'h7,         sb: 0,  sl: 2};
        #1 arst_n = 1'b0;
        #2;
        chk("rst_rdy", 32'(bus.in_rdy_o), 1);
        chk("rst_vld", 32'(bus.out_vld_o), 0);
        chk("rst_any", 32'(bus.out_any_o), 0);
        chk("rst_idx", 32'(bus.out_idx_o), 0);
        chk("rst_onehot", 32'(bus.out_onehot_o), 0);
        chk("rst_last", 32'(bus.out_last_o), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++)
            run_word(vt[t].x, vt[t].pos, vt[t].n, vt[t].seq, vt[t].sb, vt[t].sl, 1'b0);

        // Back-to-back with in_vld held high: one bubble between words.
        bus.in_vld_i = 1'b1;
        bus.in_x_i   = 8'h01;
        bus.in_pos_i = 3'd0;
        @(negedge clk);
        beat(0, 1, 3'd0, 1'b0);
        bus.in_x_i = 8'h80;
        @(negedge clk);
        chk("b2b_bubble_vld", 32'(bus.out_vld_o), 0);
        chk("b2b_bubble_rdy", 32'(bus.in_rdy_o), 1);
        @(negedge clk);
        beat(0, 1, 3'd7, 1'b0);
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("b2b_end_vld", 32'(bus.out_vld_o), 0);

        // Reset mid-word after two of four beats.
        accept(8'h96, 3'd0);
        beat(0, 4, 3'd1, 1'b0);
        @(negedge clk);
        beat(1, 4, 3'd2, 1'b0);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bus.out_vld_o), 0);
        chk("arst_rdy", 32'(bus.in_rdy_o), 1);
        chk("arst_any", 32'(bus.out_any_o), 0);
        @(negedge clk);
        arst_n = 1'b1;
        run_word(8'h04, 3'd0, 1, 32'h2, -1, 0, 1'b0);

        for (int r = 0; r < 60; r++) begin
            logic [7:0]  x;
            logic [2:0]  pos;
            int          n;
            logic [31:0] seq;
            x   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pos = 3'($urandom);
            model(x, pos, n, seq);
            run_word(x, pos, n, seq, -1, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_iter.md
# bit_iter

Set-bit iterator for the bit-scan family. It accepts one W-bit word plus a start position over a valid/ready handshake. It then emits, one per cycle, the index and one-hot of every set bit in circular order beginning at the start position (inclusive). It is the consumer-side counterpart of the single-shot scan units: it turns one scan request into the full sequence of scan results.

## Interface
- W, default 32: word width; power of two, W >= 2. Index width is $clog2(W).
- clk  input  1  clock; all state updates on the rising edge.
- arst_n  input  1  asynchronous active-low reset.
- in_vld_i  input  1  input word valid.
- in_rdy_o  output  1  block can accept a word.
- in_x_i  input  W  word to iterate.
- in_pos_i  input  $clog2(W)  start position; the scan includes this bit.
- out_vld_o  output  1  output beat valid.
- out_rdy_i  input  1  downstream accepts the beat.
- out_any_o  output  1  beat carries a real set bit. Low only for the single beat of an all-zero word.
- out_idx_o  output  $clog2(W)  encoded index of the emitted bit.
- out_onehot_o  output  W  one-hot of the emitted bit; all-zero when out_any_o=0.
- out_last_o  output  1  final beat for the current word.

## Operation
- State: IDLE, BUSY. Registers: mask_r[W], pos_r, zero_r (the captured word was zero).
- IDLE:
  - in_rdy_o=1, out_vld_o=0.
  - On in_vld_i & in_rdy_o: mask_r<=in_x_i, pos_r<=in_pos_i, zero_r<=(in_x_i==0), go to BUSY.
- BUSY:
  - in_rdy_o=0, out_vld_o=1.
  - Scan result is combinational from registers: the first set bit of mask_r at circular offset 0..W-1 from pos_r, i.e. bit (pos_r+k) mod W for the smallest k.
  - out_idx_o is its index, out_onehot_o its one-hot, out_any_o=~zero_r.
  - out_last_o=1 when mask_r has at most one bit set.
- On out handshake (out_vld_o & out_rdy_i):
  - Clear the emitted bit in mask_r.
  - If out_last_o, go to IDLE; otherwise stay in BUSY.
  - pos_r does not change. Clearing emitted bits alone advances the order.
- Zero word: exactly one beat, with out_any_o=0, out_idx_o=0, out_onehot_o=0, out_last_o=1.
- Stall: while out_vld_o=1 and out_rdy_i=0, every out_* signal holds stable and mask_r is unchanged.
- Index arithmetic is modulo W. Offsets wrap from W-1 to 0 with no dead cycle.
- A word with N set bits (N >= 1) produces exactly N beats, each index exactly once, in ascending circular order from in_pos_i.

## Timing
- Reset (async assert, sync release behaviour via flops): state=IDLE, mask_r=0, pos_r=0, zero_r=0. Outputs read in_rdy_o=1, out_vld_o=0, out_any_o=0, out_idx_o=0, out_onehot_o=0, out_last_o=0.
- Latency: a word accepted on edge N gives its first beat with out_vld_o=1 after edge N.
- Throughput: one beat per cycle while out_rdy_i=1.
- Between words: the last handshake returns to IDLE, and the next word is accepted on the following edge. That is one bubble cycle with out_vld_o=0 between words. in_rdy_o does not depend on out_rdy_i.
- in_vld_i is ignored in BUSY. The upstream holds its word until in_rdy_o.
- Reset during BUSY: the word is discarded immediately and no further beats are emitted. out_vld_o drops asynchronously.
- No combinational path from in_* to out_*. out_* depends only on registers.
- in_rdy_o depends only on state.

## Test plan
- W=8, x=8'b1001_0110, pos=0, out_rdy_i=1: idx 1,2,4,7 on four consecutive cycles with last only on 7, then in_rdy_o=1 on the next cycle.
- W=8, x=8'b1001_0110, pos=5: idx 7,1,2,4 (wrap), onehot 8'h80,8'h02,8'h04,8'h10, last on idx 4.
- W=8, x=8'h00, pos=3: single beat with out_any_o=0, idx 0, onehot 0, last=1, then IDLE.
- W=8, x=8'hFF, pos=7, out_rdy_i low for 3 cycles on the second beat: beats 7,0,1..6. The beat for idx 0 holds stable for 3 cycles, and no index is skipped or repeated.
- Back-to-back: word A=8'h01 then B=8'h80, in_vld_i held high throughout. A accepted, beat idx 0 with last, one bubble, B accepted, beat idx 7.
- Assert arst_n=0 mid-word after 2 of 4 beats: out_vld_o=0 immediately. After release, in_rdy_o=1, and a new word x=8'h04 yields a single beat idx 2.
